// File: rtl/pacman_pkg.sv
// pacman_pkg: types and helpers shared by the Pac-Man motion controller and the sprite path.
//   dir_t       facing/request encoding (RT=00, UP=01, DN=10, LT=11)
//   state_t     motion FSM states
//   FRAME_*     sprite animation frame numbers
//   step_pos()  one-step candidate position with horizontal tunnel wrap
package pacman_pkg;

   typedef enum logic [1:0] {
      DirRt = 2'd0,
      DirUp = 2'd1,
      DirDn = 2'd2,
      DirLt = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StProbeTurn = 2'd1,
      StProbeFwd  = 2'd2,
      StDead      = 2'd3
   } state_t;

   localparam logic [1:0] FRAME_OPEN   = 2'd0;
   localparam logic [1:0] FRAME_HALF   = 2'd1;
   localparam logic [1:0] FRAME_CLOSED = 2'd2;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } pos_t;

   // Phase index 0..3 walks the frames open, half, closed, half.
   function automatic logic [1:0] phase_frame(input logic [1:0] ph);
      logic [1:0] f;
      unique case (ph)
         2'd0:    f = FRAME_OPEN;
         2'd1:    f = FRAME_HALF;
         2'd2:    f = FRAME_CLOSED;
         default: f = FRAME_HALF;
      endcase
      return f;
   endfunction

   // x wraps through the tunnel; y never wraps because the maze walls stop it first.
   function automatic pos_t step_pos(input logic [9:0] x, input logic [9:0] y, input dir_t d,
                                     input int unsigned step, input int unsigned xmin,
                                     input int unsigned xmax);
      pos_t        p;
      logic [10:0] xs;
      p.x = x;
      p.y = y;
      xs  = {1'b0, x} + 11'(step);
      unique case (d)
         DirRt: p.x = (xs > 11'(xmax)) ? 10'(xmin) : xs[9:0];
         // x - step < xmin, written without underflow so x < step also wraps.
         DirLt: p.x = ({1'b0, x} < (11'(step) + 11'(xmin))) ? 10'(xmax) : (x - 10'(step));
         DirUp: p.y = y - 10'(step);
         default: p.y = y + 10'(step);
      endcase
      return p;
   endfunction

endpackage

// File: rtl/pacman_anim_seq.sv
// pacman_anim_seq: chomp animation sequencer.
//   clk, rst_n       clock, asynchronous active-low reset
//   advance_i        a committed (moving) frame
//   hold_i           a blocked frame; counter and frame hold
//   force_closed_i   death: show the closed frame, sequence state untouched
//   restart_i        respawn: counter and phase back to zero, frame open
//   frame_o          registered sprite frame (0..2)
module pacman_anim_seq
   import pacman_pkg::*;
#(
   parameter int unsigned ANIM_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       advance_i,
   input  logic       hold_i,
   input  logic       force_closed_i,
   input  logic       restart_i,
   output logic [1:0] frame_o
);

   localparam int unsigned CntW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ANIM_FRAMES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      ph_q, ph_d;
   logic [1:0]      frame_q, frame_d;

   always_comb begin
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      frame_d = frame_q;
      if (restart_i) begin
         cnt_d   = '0;
         ph_d    = '0;
         frame_d = FRAME_OPEN;
      end else if (force_closed_i) begin
         frame_d = FRAME_CLOSED;
      end else if (advance_i && !hold_i) begin
         if (cnt_q == CntLast) begin
            cnt_d   = '0;
            ph_d    = ph_q + 2'd1;
            frame_d = phase_frame(ph_q + 2'd1);
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         ph_q    <= '0;
         frame_q <= FRAME_OPEN;
      end else begin
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         frame_q <= frame_d;
      end
   end

   assign frame_o = frame_q;

endmodule

// File: rtl/pacman_motion.sv
// pacman_motion: per-frame Pac-Man movement, maze probe handshake, death/respawn.
//   clk, rst_n                  clock, asynchronous active-low reset
//   frame_tick_i                one-cycle pulse at start of vertical blank
//   dir_req_i, dir_req_valid_i  requested direction, latched as the pending turn
//   kill_i                      one-cycle collision pulse
//   probe_req_o, probe_x_o,
//   probe_y_o                   maze legality query (held until ack)
//   probe_ack_i, probe_ok_i     query answer; ok sampled only with ack
//   xloc_o, yloc_o              sprite centre
//   pacman_dir_o                facing
//   pacman_alive_o              1 = alive
//   animation_cycle_o           sprite frame 0..2
//   overrun_o                   frame_tick arrived while a probe was still open
module pacman_motion
   import pacman_pkg::*;
#(
   parameter int unsigned START_X      = 320,
   parameter int unsigned START_Y      = 372,
   parameter int unsigned STEP         = 1,
   parameter int unsigned XMIN         = 7,
   parameter int unsigned XMAX         = 632,
   parameter int unsigned ANIM_FRAMES  = 4,
   parameter int unsigned DEATH_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick_i,
   input  logic [1:0] dir_req_i,
   input  logic       dir_req_valid_i,
   input  logic       kill_i,
   output logic       probe_req_o,
   output logic [9:0] probe_x_o,
   output logic [9:0] probe_y_o,
   input  logic       probe_ack_i,
   input  logic       probe_ok_i,
   output logic [9:0] xloc_o,
   output logic [9:0] yloc_o,
   output logic [1:0] pacman_dir_o,
   output logic       pacman_alive_o,
   output logic [1:0] animation_cycle_o,
   output logic       overrun_o
);

   localparam int unsigned DcW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
   localparam logic [DcW-1:0] DeathLast = DcW'(DEATH_FRAMES - 1);
   localparam logic [9:0] StartX = 10'(START_X);
   localparam logic [9:0] StartY = 10'(START_Y);

   state_t state_q, state_d;

   logic [9:0]     x_q, x_d, y_q, y_d;
   dir_t           dir_q, dir_d;
   logic           alive_q, alive_d;
   logic           probe_req_q, probe_req_d;
   logic [9:0]     probe_x_q, probe_x_d, probe_y_q, probe_y_d;
   dir_t           probe_dir_q, probe_dir_d;
   dir_t           pend_dir_q, pend_dir_d;
   logic           pend_vld_q, pend_vld_d;
   logic           overrun_q, overrun_d;
   logic [DcW-1:0] death_cnt_q, death_cnt_d;

   logic anim_advance, anim_hold, anim_force, anim_restart;
   logic ack_v, kill_v;
   pos_t fwd_pos, turn_pos;

   // Acks outside an open request are ignored; kill only acts on a live sprite.
   assign ack_v  = probe_ack_i & probe_req_q;
   assign kill_v = kill_i & (state_q != StDead);

   assign fwd_pos  = step_pos(x_q, y_q, dir_q, STEP, XMIN, XMAX);
   assign turn_pos = step_pos(x_q, y_q, pend_dir_q, STEP, XMIN, XMAX);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (kill_v) begin
         state_d = StDead;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (frame_tick_i) state_d = pend_vld_q ? StProbeTurn : StProbeFwd;
            end
            StProbeTurn: begin
               if (ack_v) state_d = probe_ok_i ? StIdle : StProbeFwd;
            end
            StProbeFwd: begin
               if (ack_v) state_d = StIdle;
            end
            default: begin
               if (frame_tick_i && (death_cnt_q == DeathLast)) state_d = StIdle;
            end
         endcase
      end
   end

   // Datapath and output next-values
   always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      dir_d        = dir_q;
      alive_d      = alive_q;
      probe_req_d  = probe_req_q;
      probe_x_d    = probe_x_q;
      probe_y_d    = probe_y_q;
      probe_dir_d  = probe_dir_q;
      pend_dir_d   = pend_dir_q;
      pend_vld_d   = pend_vld_q;
      overrun_d    = 1'b0;
      death_cnt_d  = death_cnt_q;
      anim_advance = 1'b0;
      anim_hold    = 1'b0;
      anim_force   = 1'b0;
      anim_restart = 1'b0;

      if (dir_req_valid_i) begin
         pend_dir_d = dir_t'(dir_req_i);
         pend_vld_d = 1'b1;
      end

      if (kill_v) begin
         // Any open request is abandoned; kill beats a same-cycle ack.
         alive_d     = 1'b0;
         probe_req_d = 1'b0;
         pend_vld_d  = 1'b0;
         death_cnt_d = '0;
         anim_force  = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (frame_tick_i) begin
                  probe_req_d = 1'b1;
                  if (pend_vld_q) begin
                     probe_x_d   = turn_pos.x;
                     probe_y_d   = turn_pos.y;
                     probe_dir_d = pend_dir_q;
                  end else begin
                     probe_x_d   = fwd_pos.x;
                     probe_y_d   = fwd_pos.y;
                     probe_dir_d = dir_q;
                  end
               end
            end
            StProbeTurn: begin
               overrun_d = frame_tick_i;
               if (ack_v) begin
                  if (probe_ok_i) begin
                     x_d          = probe_x_q;
                     y_d          = probe_y_q;
                     dir_d        = probe_dir_q;
                     probe_req_d  = 1'b0;
                     anim_advance = 1'b1;
                     // A fresh request arriving this cycle stays pending.
                     if (!dir_req_valid_i) pend_vld_d = 1'b0;
                  end else begin
                     probe_x_d   = fwd_pos.x;
                     probe_y_d   = fwd_pos.y;
                     probe_dir_d = dir_q;
                  end
               end
            end
            StProbeFwd: begin
               overrun_d = frame_tick_i;
               if (ack_v) begin
                  probe_req_d = 1'b0;
                  if (probe_ok_i) begin
                     x_d          = probe_x_q;
                     y_d          = probe_y_q;
                     anim_advance = 1'b1;
                  end else begin
                     anim_hold = 1'b1;
                  end
               end
            end
            default: begin
               if (frame_tick_i) begin
                  if (death_cnt_q == DeathLast) begin
                     x_d          = StartX;
                     y_d          = StartY;
                     dir_d        = DirLt;
                     alive_d      = 1'b1;
                     death_cnt_d  = '0;
                     anim_restart = 1'b1;
                  end else begin
                     death_cnt_d = death_cnt_q + DcW'(1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q         <= StartX;
         y_q         <= StartY;
         dir_q       <= DirLt;
         alive_q     <= 1'b1;
         probe_req_q <= 1'b0;
         probe_x_q   <= StartX;
         probe_y_q   <= StartY;
         probe_dir_q <= DirLt;
         pend_dir_q  <= DirLt;
         pend_vld_q  <= 1'b0;
         overrun_q   <= 1'b0;
         death_cnt_q <= '0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         dir_q       <= dir_d;
         alive_q     <= alive_d;
         probe_req_q <= probe_req_d;
         probe_x_q   <= probe_x_d;
         probe_y_q   <= probe_y_d;
         probe_dir_q <= probe_dir_d;
         pend_dir_q  <= pend_dir_d;
         pend_vld_q  <= pend_vld_d;
         overrun_q   <= overrun_d;
         death_cnt_q <= death_cnt_d;
      end
   end

   pacman_anim_seq #(
      .ANIM_FRAMES(ANIM_FRAMES)
   ) u_anim (
      .clk           (clk),
      .rst_n         (rst_n),
      .advance_i     (anim_advance),
      .hold_i        (anim_hold),
      .force_closed_i(anim_force),
      .restart_i     (anim_restart),
      .frame_o       (animation_cycle_o)
   );

   assign probe_req_o    = probe_req_q;
   assign probe_x_o      = probe_x_q;
   assign probe_y_o      = probe_y_q;
   assign xloc_o         = x_q;
   assign yloc_o         = y_q;
   assign pacman_dir_o   = dir_q;
   assign pacman_alive_o = alive_q;
   assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed bench for pacman_motion with default parameters.
module tb_pacman_motion;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic [1:0] dir_req = 2'd0;
   logic       dir_req_valid = 1'b0;
   logic       kill = 1'b0;
   logic       probe_req;
   logic [9:0] probe_x, probe_y;
   logic       probe_ack = 1'b0;
   logic       probe_ok = 1'b0;
   logic [9:0] xloc, yloc;
   logic [1:0] pacman_dir;
   logic       pacman_alive;
   logic [1:0] animation_cycle;
   logic       overrun;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pacman_motion dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .frame_tick_i     (frame_tick),
      .dir_req_i        (dir_req),
      .dir_req_valid_i  (dir_req_valid),
      .kill_i           (kill),
      .probe_req_o      (probe_req),
      .probe_x_o        (probe_x),
      .probe_y_o        (probe_y),
      .probe_ack_i      (probe_ack),
      .probe_ok_i       (probe_ok),
      .xloc_o           (xloc),
      .yloc_o           (yloc),
      .pacman_dir_o     (pacman_dir),
      .pacman_alive_o   (pacman_alive),
      .animation_cycle_o(animation_cycle),
      .overrun_o        (overrun)
   );

   typedef struct {
      bit         req_v;
      logic [1:0] req_dir;
      bit         two;      // first probe rejected, second probe follows
      int         p1x, p1y;
      bit         ok1;
      int         p2x, p2y;
      bit         ok2;
      int         ex, ey;
      logic [1:0] edir;
      int         eanim;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic wait_req(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (probe_req) begin
            seen = 1'b1;
            break;
         end
         cyc();
      end
      if (!seen) chk({name, "_req_timeout"}, 32'(probe_req), 32'd1);
   endtask

   task automatic ack(input bit ok);
      probe_ack = 1'b1;
      probe_ok  = ok;
      cyc();
      probe_ack = 1'b0;
      probe_ok  = 1'b0;
   endtask

   // One frame: tick, bounded wait for the probe, ack after two cycles.
   task automatic simple_frame(input bit ok);
      pulse_tick();
      wait_req("simple");
      cyc();
      cyc();
      ack(ok);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_x"}, 32'(xloc), 32'd320);
      chk({tag, "_y"}, 32'(yloc), 32'd372);
      chk({tag, "_dir"}, 32'(pacman_dir), 32'd3);
      chk({tag, "_alive"}, 32'(pacman_alive), 32'd1);
      chk({tag, "_anim"}, 32'(animation_cycle), 32'd0);
      chk({tag, "_req"}, 32'(probe_req), 32'd0);
      chk({tag, "_ovr"}, 32'(overrun), 32'd0);
   endtask

   initial begin
      // req_v dir two  p1x  p1y ok1 p2x  p2y ok2  ex   ey  dir anim
      vecs[0]  = '{0, 2'd0, 0, 319, 372, 1, 0,   0,   0, 319, 372, 2'd3, 0};
      vecs[1]  = '{0, 2'd0, 0, 318, 372, 1, 0,   0,   0, 318, 372, 2'd3, 0};
      vecs[2]  = '{0, 2'd0, 0, 317, 372, 1, 0,   0,   0, 317, 372, 2'd3, 0};
      vecs[3]  = '{0, 2'd0, 0, 316, 372, 1, 0,   0,   0, 316, 372, 2'd3, 1};
      vecs[4]  = '{0, 2'd0, 0, 315, 372, 1, 0,   0,   0, 315, 372, 2'd3, 1};
      vecs[5]  = '{0, 2'd0, 0, 314, 372, 1, 0,   0,   0, 314, 372, 2'd3, 1};
      vecs[6]  = '{0, 2'd0, 0, 313, 372, 1, 0,   0,   0, 313, 372, 2'd3, 1};
      vecs[7]  = '{0, 2'd0, 0, 312, 372, 1, 0,   0,   0, 312, 372, 2'd3, 2};
      vecs[8]  = '{0, 2'd0, 0, 311, 372, 1, 0,   0,   0, 311, 372, 2'd3, 2};
      vecs[9]  = '{0, 2'd0, 0, 310, 372, 1, 0,   0,   0, 310, 372, 2'd3, 2};
      vecs[10] = '{0, 2'd0, 0, 309, 372, 1, 0,   0,   0, 309, 372, 2'd3, 2};
      vecs[11] = '{0, 2'd0, 0, 308, 372, 1, 0,   0,   0, 308, 372, 2'd3, 1};
      vecs[12] = '{0, 2'd0, 0, 307, 372, 0, 0,   0,   0, 308, 372, 2'd3, 1};
      vecs[13] = '{0, 2'd0, 0, 307, 372, 0, 0,   0,   0, 308, 372, 2'd3, 1};
      vecs[14] = '{1, 2'd1, 1, 308, 371, 0, 307, 372, 1, 307, 372, 2'd3, 1};
      vecs[15] = '{0, 2'd0, 0, 307, 371, 1, 0,   0,   0, 307, 371, 2'd1, 1};
      vecs[16] = '{0, 2'd0, 0, 307, 370, 0, 0,   0,   0, 307, 371, 2'd1, 1};
      vecs[17] = '{1, 2'd2, 0, 307, 372, 1, 0,   0,   0, 307, 372, 2'd2, 1};
      vecs[18] = '{0, 2'd0, 0, 307, 373, 1, 0,   0,   0, 307, 373, 2'd2, 0};
      vecs[19] = '{1, 2'd0, 0, 308, 373, 1, 0,   0,   0, 308, 373, 2'd0, 0};

      // Reset values, held in reset and after release.
      #12;
      chk_reset_vals("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk_reset_vals("after_reset");

      // Table-driven frames.
      for (int i = 0; i < 20; i++) begin
         if (vecs[i].req_v) begin
            dir_req_valid = 1'b1;
            dir_req       = vecs[i].req_dir;
            cyc();
            dir_req_valid = 1'b0;
         end
         pulse_tick();
         chk($sformatf("v%0d_req_latency", i), 32'(probe_req), 32'd1);
         chk($sformatf("v%0d_p1x", i), 32'(probe_x), 32'(vecs[i].p1x));
         chk($sformatf("v%0d_p1y", i), 32'(probe_y), 32'(vecs[i].p1y));
         cyc();
         cyc();
         chk($sformatf("v%0d_p1x_stable", i), 32'(probe_x), 32'(vecs[i].p1x));
         ack(vecs[i].ok1);
         if (vecs[i].two) begin
            chk($sformatf("v%0d_req2", i), 32'(probe_req), 32'd1);
            chk($sformatf("v%0d_p2x", i), 32'(probe_x), 32'(vecs[i].p2x));
            chk($sformatf("v%0d_p2y", i), 32'(probe_y), 32'(vecs[i].p2y));
            ack(vecs[i].ok2);
         end
         chk($sformatf("v%0d_req_done", i), 32'(probe_req), 32'd0);
         chk($sformatf("v%0d_x", i), 32'(xloc), 32'(vecs[i].ex));
         chk($sformatf("v%0d_y", i), 32'(yloc), 32'(vecs[i].ey));
         chk($sformatf("v%0d_dir", i), 32'(pacman_dir), 32'(vecs[i].edir));
         chk($sformatf("v%0d_anim", i), 32'(animation_cycle), 32'(vecs[i].eanim));
      end

      // Walk from x=320 down to the low tunnel bound, then wrap both ways.
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      cyc();
      for (int i = 0; i < 313; i++) simple_frame(1'b1);
      chk("walk_x", 32'(xloc), 32'd7);
      pulse_tick();
      chk("wrap_lt_probe_x", 32'(probe_x), 32'd632);
      ack(1'b1);
      chk("wrap_lt_x", 32'(xloc), 32'd632);
      dir_req_valid = 1'b1;
      dir_req       = 2'd0;
      cyc();
      dir_req_valid = 1'b0;
      pulse_tick();
      chk("wrap_rt_probe_x", 32'(probe_x), 32'd7);
      ack(1'b1);
      chk("wrap_rt_x", 32'(xloc), 32'd7);
      chk("wrap_rt_dir", 32'(pacman_dir), 32'd0);

      // Kill coincident with an ok ack: no commit, pending turn dropped.
      dir_req_valid = 1'b1;
      dir_req       = 2'd1;
      cyc();
      dir_req_valid = 1'b0;
      pulse_tick();
      chk("kill_turn_probe_y", 32'(probe_y), 32'd371);
      cyc();
      kill      = 1'b1;
      probe_ack = 1'b1;
      probe_ok  = 1'b1;
      cyc();
      kill      = 1'b0;
      probe_ack = 1'b0;
      probe_ok  = 1'b0;
      chk("kill_x", 32'(xloc), 32'd7);
      chk("kill_y", 32'(yloc), 32'd372);
      chk("kill_alive", 32'(pacman_alive), 32'd0);
      chk("kill_anim", 32'(animation_cycle), 32'd2);
      chk("kill_req", 32'(probe_req), 32'd0);
      for (int i = 0; i < 59; i++) begin
         pulse_tick();
         if (i == 30) kill = 1'b1;  // ignored while dead
         cyc();
         kill = 1'b0;
      end
      chk("dead_59_alive", 32'(pacman_alive), 32'd0);
      chk("dead_no_overrun", 32'(overrun), 32'd0);
      pulse_tick();
      chk_reset_vals("respawn");
      pulse_tick();
      chk("respawn_fwd_probe_x", 32'(probe_x), 32'd319);
      chk("respawn_fwd_probe_y", 32'(probe_y), 32'd372);
      ack(1'b1);
      chk("respawn_move_x", 32'(xloc), 32'd319);

      // A second tick while the probe is open: one overrun pulse, one move.
      pulse_tick();
      cyc();
      pulse_tick();
      chk("overrun_hi", 32'(overrun), 32'd1);
      cyc();
      chk("overrun_lo", 32'(overrun), 32'd0);
      ack(1'b1);
      for (int i = 0; i < 4; i++) cyc();
      chk("overrun_req_idle", 32'(probe_req), 32'd0);
      chk("overrun_single_move", 32'(xloc), 32'd318);

      // Asynchronous reset in the middle of an open probe.
      pulse_tick();
      chk("midprobe_req", 32'(probe_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
